// File: rtl/alu_pkg.sv
// Shared op codes and controller state encoding for the accumulator ALU.
package alu_pkg;

  localparam logic [1:0] OP_ADD   = 2'd0;
  localparam logic [1:0] OP_SUB   = 2'd1;
  localparam logic [1:0] OP_NOT   = 2'd2;
  localparam logic [1:0] OP_CARRY = 2'd3;

  localparam int DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    HOLD = 2'd2
  } state_e;

endpackage

// File: rtl/add_sub_logic.sv
// Shared adder/subtractor: sub=1 computes a-b as a+~b+1, carry is the adder's top bit.
module add_sub_logic #(
  parameter int W = 16
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sub,
  output logic [W-1:0] sum,
  output logic         carry
);

  logic [W:0]   full;
  logic [W-1:0] b_eff;

  always_comb begin
    b_eff = sub ? ~b : b;
    full  = {1'b0, a} + {1'b0, b_eff} + {{W{1'b0}}, sub};
    sum   = full[W-1:0];
    carry = full[W];
  end

endmodule

// File: rtl/alu_accumulator.sv
// Handshaked accumulator ALU: IDLE accepts a command, EXEC updates acc, HOLD presents the result.
module alu_accumulator
  import alu_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_load,
  input  logic [1:0]        cmd_op,
  input  logic [15:0]       cmd_operand,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [15:0]       res_data,
  output logic [15:0]       acc,
  output logic [CNT_W-1:0]  op_count
);

  state_e             state_q, state_d;
  logic               load_q, load_d;
  logic [1:0]         op_q, op_d;
  logic [15:0]        operand_q, operand_d;
  logic [15:0]        acc_q, acc_d;
  logic [15:0]        res_data_q, res_data_d;
  logic [CNT_W-1:0]   op_count_q, op_count_d;
  logic               cmd_ready_q, cmd_ready_d;
  logic               res_valid_q, res_valid_d;

  logic [15:0]        sum;
  logic               carry;
  logic [15:0]        alu_r;

  add_sub_logic #(.W(16)) u_add_sub (
    .a     (acc_q),
    .b     (operand_q),
    .sub   (op_q == OP_SUB),
    .sum   (sum),
    .carry (carry)
  );

  always_comb begin
    alu_r = sum;
    case (op_q)
      OP_ADD:   alu_r = sum;
      OP_SUB:   alu_r = sum;
      OP_NOT:   alu_r = ~operand_q;
      OP_CARRY: alu_r = {15'd0, carry};
      default:  alu_r = sum;
    endcase
  end

  // Handshake flags are derived from the next state so every output stays registered.
  always_comb begin
    state_d    = state_q;
    load_d     = load_q;
    op_d       = op_q;
    operand_d  = operand_q;
    acc_d      = acc_q;
    res_data_d = res_data_q;
    op_count_d = op_count_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          state_d   = EXEC;
          load_d    = cmd_load;
          op_d      = cmd_op;
          operand_d = cmd_operand;
        end
      end
      EXEC: begin
        state_d    = HOLD;
        acc_d      = load_q ? operand_q : alu_r;
        res_data_d = acc_d;
        op_count_d = op_count_q + CNT_W'(1);
      end
      HOLD: begin
        if (res_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    cmd_ready_d = (state_d == IDLE);
    res_valid_d = (state_d == HOLD);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      load_q      <= 1'b0;
      op_q        <= OP_ADD;
      operand_q   <= 16'd0;
      acc_q       <= 16'd0;
      res_data_q  <= 16'd0;
      op_count_q  <= '0;
      cmd_ready_q <= 1'b0;
      res_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      load_q      <= load_d;
      op_q        <= op_d;
      operand_q   <= operand_d;
      acc_q       <= acc_d;
      res_data_q  <= res_data_d;
      op_count_q  <= op_count_d;
      cmd_ready_q <= cmd_ready_d;
      res_valid_q <= res_valid_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign acc       = acc_q;
  assign op_count  = op_count_q;

endmodule

// File: tb/tb_alu_accumulator.sv
// Randomised and directed bench for alu_accumulator against an arithmetic reference model.
module tb_alu_accumulator;

  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic             cmd_load = 1'b0;
  logic [1:0]       cmd_op = 2'd0;
  logic [15:0]      cmd_operand = 16'd0;
  logic             res_valid;
  logic             res_ready = 1'b0;
  logic [15:0]      res_data;
  logic [15:0]      acc;
  logic [CNT_W-1:0] op_count;

  int checks = 0;
  int errors = 0;
  int acc_m = 0;
  int count_m = 0;

  alu_accumulator #(.CNT_W(CNT_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_load    (cmd_load),
    .cmd_op      (cmd_op),
    .cmd_operand (cmd_operand),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_data    (res_data),
    .acc         (acc),
    .op_count    (op_count)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Reference result straight from the op definitions, using plain integer arithmetic.
  function automatic int modelResult(input bit load, input int op, input int a, input int b);
    if (load) return b;
    case (op)
      0:       return (a + b) % 65536;
      1:       return (a - b + 65536) % 65536;
      2:       return 65535 - b;
      default: return (a + b) / 65536;
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic scrambleCmd();
    cmd_load    = 1'($urandom);
    cmd_op      = 2'($urandom);
    cmd_operand = 16'($urandom);
  endtask

  task automatic waitReady();
    int n = 0;
    while (cmd_ready !== 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    checkOutput("cmd_ready_wait", {31'd0, cmd_ready}, 32'd1);
  endtask

  task automatic applyStimulus(input bit load, input logic [1:0] op, input logic [15:0] operand,
                               input int hold_cycles);
    int expected;
    waitReady();
    cmd_valid   = 1'b1;
    cmd_load    = load;
    cmd_op      = op;
    cmd_operand = operand;
    expected    = modelResult(load, int'(op), acc_m, int'(operand));
    @(negedge clk);
    checkOutput("exec_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    checkOutput("exec_res_valid", {31'd0, res_valid}, 32'd0);
    checkOutput("exec_acc", {16'd0, acc}, acc_m);
    cmd_valid = 1'b0;
    res_ready = 1'($urandom);
    scrambleCmd();
    @(negedge clk);
    res_ready = 1'b0;
    acc_m   = expected;
    count_m = (count_m + 1) % (1 << CNT_W);
    checkOutput("hold_res_valid", {31'd0, res_valid}, 32'd1);
    checkOutput("hold_res_data", {16'd0, res_data}, expected);
    checkOutput("hold_acc", {16'd0, acc}, expected);
    checkOutput("hold_op_count", {24'd0, op_count}, count_m);
    for (int i = 0; i < hold_cycles; i++) begin
      cmd_valid = 1'b1;
      scrambleCmd();
      @(negedge clk);
      checkOutput("bp_res_valid", {31'd0, res_valid}, 32'd1);
      checkOutput("bp_res_data", {16'd0, res_data}, expected);
      checkOutput("bp_acc", {16'd0, acc}, expected);
      checkOutput("bp_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    end
    cmd_valid = 1'b0;
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    checkOutput("idle_res_valid", {31'd0, res_valid}, 32'd0);
    checkOutput("idle_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    checkOutput("idle_op_count", {24'd0, op_count}, count_m);
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_acc"}, {16'd0, acc}, 32'd0);
    checkOutput({tag, "_res_data"}, {16'd0, res_data}, 32'd0);
    checkOutput({tag, "_op_count"}, {24'd0, op_count}, 32'd0);
    checkOutput({tag, "_res_valid"}, {31'd0, res_valid}, 32'd0);
    checkOutput({tag, "_cmd_ready"}, {31'd0, cmd_ready}, 32'd0);
  endtask

  initial begin
    #12;
    checkResetState("reset");
    @(negedge clk);
    reset = 1'b0;
    checkOutput("ready_before_edge", {31'd0, cmd_ready}, 32'd0);
    @(negedge clk);
    checkOutput("ready_after_edge", {31'd0, cmd_ready}, 32'd1);

    $display("[TB] load then add");
    applyStimulus(1'b1, 2'd0, 16'd2, 0);
    checkOutput("load2_acc", {16'd0, acc}, 32'd2);
    applyStimulus(1'b0, 2'd0, 16'd3, 0);
    checkOutput("add3_acc", {16'd0, acc}, 32'd5);
    checkOutput("add3_count", {24'd0, op_count}, 32'd2);

    $display("[TB] subtract and carry");
    applyStimulus(1'b1, 2'd3, 16'd100, 0);
    applyStimulus(1'b0, 2'd1, 16'd200, 0);
    checkOutput("sub_res", {16'd0, res_data}, 32'h0000_FF9C);
    applyStimulus(1'b0, 2'd3, 16'h0064, 0);
    checkOutput("carry_res", {16'd0, res_data}, 32'd1);

    $display("[TB] invert");
    applyStimulus(1'b1, 2'd1, 16'd7, 0);
    applyStimulus(1'b0, 2'd2, 16'd11, 0);
    checkOutput("not_res", {16'd0, res_data}, 32'h0000_FFF4);

    $display("[TB] backpressure");
    applyStimulus(1'b0, 2'd0, 16'($urandom), 5);

    $display("[TB] random commands");
    for (int i = 0; i < 40; i++) begin
      applyStimulus(1'($urandom_range(0, 3) == 0), 2'($urandom), 16'($urandom),
                    int'($urandom_range(0, 2)));
    end

    $display("[TB] reset during EXEC");
    waitReady();
    cmd_valid = 1'b1; cmd_load = 1'b1; cmd_operand = 16'h1234;
    @(negedge clk);
    cmd_valid = 1'b0;
    #2 reset = 1'b1;
    #1 checkResetState("exec_rst");
    acc_m = 0;
    count_m = 0;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("post_rst_res_valid", {31'd0, res_valid}, 32'd0);
      checkOutput("post_rst_acc", {16'd0, acc}, 32'd0);
    end

    $display("[TB] reset during HOLD");
    applyStimulus(1'b1, 2'd0, 16'h00AA, 0);
    waitReady();
    cmd_valid = 1'b1; cmd_load = 1'b0; cmd_op = 2'd0; cmd_operand = 16'd1;
    repeat (2) @(negedge clk);
    cmd_valid = 1'b0;
    checkOutput("hold_before_rst", {31'd0, res_valid}, 32'd1);
    #3 reset = 1'b1;
    #1 checkResetState("hold_rst");
    acc_m = 0;
    count_m = 0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("hold_rst_no_result", {31'd0, res_valid}, 32'd0);

    $display("[TB] op_count wrap");
    for (int i = 0; i < 256; i++) begin
      applyStimulus(1'($urandom), 2'($urandom), 16'($urandom), 0);
    end
    checkOutput("wrap_op_count", {24'd0, op_count}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_accumulator.md
ALU_ACCUMULATOR -- requirements
Module: alu_accumulator

Interface
REQ-001 SHALL have parameter CNT_W, default 8, meaning width of the executed-operation counter.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port cmd_valid  input  1  command present.
REQ-005 SHALL have port cmd_ready  output  1  block can accept a command.
REQ-006 SHALL have port cmd_load  input  1  1 = load operand into accumulator; 0 = ALU op.
REQ-007 SHALL have port cmd_op  input  2  ALU op code, ignored when cmd_load=1.
REQ-008 SHALL have port cmd_operand  input  16  operand b.
REQ-009 SHALL have port res_valid  output  1  result available.
REQ-010 SHALL have port res_ready  input  1  consumer accepts result.
REQ-011 SHALL have port res_data  output  16  result value, equal to the new accumulator.
REQ-012 SHALL have port acc  output  16  current accumulator value.
REQ-013 SHALL have port op_count  output  CNT_W  count of completed commands.

Function
REQ-014 SHALL implement a state machine with states IDLE, EXEC and HOLD.
REQ-015 SHALL assert cmd_ready only in IDLE; a command is accepted on an edge where cmd_valid and cmd_ready are both 1.
REQ-016 SHALL, on acceptance, register cmd_load, cmd_op and cmd_operand and move from IDLE to EXEC.
REQ-017 SHALL, in EXEC, drive the ALU with a=acc, b=registered operand, op=registered op.
REQ-018 SHALL use these ALU ops: 0 a+b mod 2^16; 1 a-b mod 2^16; 2 ~b; 3 carry-out of a+b, zero-extended to 16 bits.
REQ-019 SHALL, on the EXEC edge, write acc and res_data with the operand (load) or the ALU r (op), increment op_count, and move to HOLD.
REQ-020 SHALL wrap op_count from all-ones to 0 without saturation or flag.
REQ-021 SHALL assert res_valid only in HOLD, with res_data held stable until accepted.
REQ-022 SHALL move from HOLD to IDLE on an edge where res_ready=1; res_ready outside HOLD SHALL be ignored.
REQ-023 SHALL give fixed latency: command accepted at edge N, res_valid high after edge N+1; one command in flight at most.
REQ-024 SHALL ignore cmd_valid in EXEC and HOLD, so cmd_* inputs may change freely while cmd_ready=0.
REQ-025 SHALL keep acc unchanged except on the EXEC edge.

Reset
REQ-026 SHALL, while reset=1 and independent of clk, force state to IDLE, acc=0, res_data=0, op_count=0, res_valid=0, cmd_ready=0.
REQ-027 SHALL assert cmd_ready from the first rising clk edge after reset deasserts.
REQ-028 SHALL discard any command in EXEC or result in HOLD when reset asserts mid-operation; no result is delivered.

Structure
REQ-029 SHALL take op-code constants (OP_ADD=0, OP_SUB=1, OP_NOT=2, OP_CARRY=3) and the state enum from a shared package alu_pkg.
REQ-030 SHALL instantiate the existing add_sub_logic as its only sub-module; no duplicate adder logic.
REQ-031 SHALL register all outputs; no combinational path from cmd_* or res_ready to any output.

Verification
REQ-032 SHALL pass: reset, then load 2, then op0 operand 3 -> res_data=2 then 5, acc=5, op_count=2.
REQ-033 SHALL pass: load 100, then op1 operand 200 -> res_data=16'hFF9C; then op3 operand 16'h0064 -> res_data=1.
REQ-034 SHALL pass: load 7, then op2 operand 11 -> res_data=~16'd11 (16'hFFF4).
REQ-035 SHALL pass backpressure: res_ready=0 for 5 cycles -> res_valid and res_data stable, cmd_ready=0, and a cmd_valid pulse meanwhile is ignored (acc unchanged).
REQ-036 SHALL pass: reset asserted during EXEC -> acc=0, res_valid=0 immediately; 256 completed commands with CNT_W=8 -> op_count wraps to 0.
